// File: rtl/cpu_defs.sv
// Shared pipeline definitions: word widths, memory op and exception encodings,
// and the MEM/WB pipeline register layout.
package cpu_defs;

    localparam int WORD        = 32;
    localparam int WORD_ADDR_W = 30;
    localparam int GPR_ADDR_W  = 5;
    localparam int EXP_W       = 3;

    localparam logic [1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    localparam logic [EXP_W-1:0] EXP_NONE     = 3'd0;
    localparam logic [EXP_W-1:0] EXP_INT      = 3'd1;
    localparam logic [EXP_W-1:0] EXP_OVF      = 3'd3;
    localparam logic [EXP_W-1:0] EXP_MISALIGN = 3'd4;
    localparam logic [EXP_W-1:0] EXP_BUSERR   = 3'd5;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_REQ    = 2'd1,
        BUS_ACCESS = 2'd2
    } bus_state_e;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic                   en;
        logic                   br_flag;
        logic [1:0]             ctrl_op;
        logic [GPR_ADDR_W-1:0]  dst_addr;
        logic                   gpr_we_;
        logic [EXP_W-1:0]       exp_code;
        logic [WORD-1:0]        out;
    } memwb_t;

    localparam memwb_t MEMWB_BUBBLE = '{
        pc:       '0,
        en:       1'b0,
        br_flag:  1'b0,
        ctrl_op:  2'b00,
        dst_addr: '0,
        gpr_we_:  1'b1,
        exp_code: EXP_NONE,
        out:      '0
    };

    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Request/grant bus master for the MEM stage: access FSM, bus timeout counter
// and registered bus outputs. Reports busy/done/timeout back to the stage.
import cpu_defs::*;

module mem_bus_if #(
    parameter int BUS_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   acc,
    input  logic                   acc_rd,
    input  logic [WORD_ADDR_W-1:0] acc_addr,
    input  logic [WORD-1:0]        acc_wr_data,
    input  logic                   bus_grant,
    input  logic                   bus_rdy,
    input  logic [WORD-1:0]        bus_rd_data,
    output logic                   bus_req,
    output logic                   bus_as,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]        bus_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [WORD-1:0]        rd_data
);

    bus_state_e             state_q;
    logic [TO_W-1:0]        cnt_q;
    logic                   bus_req_q;
    logic                   bus_as_q;
    logic                   bus_rw_q;
    logic [WORD_ADDR_W-1:0] bus_addr_q;
    logic [WORD-1:0]        bus_wr_data_q;

    logic start;
    logic expire;

    // A flushed request completes at once as a bubble, so it never starts or stalls.
    assign start   = (state_q == BUS_IDLE) && acc && !flush;
    assign expire  = (state_q != BUS_IDLE) && (cnt_q == TO_W'(BUS_TIMEOUT - 1));
    assign done    = (state_q == BUS_ACCESS) && bus_rdy;
    assign timeout = expire && !done;

    assign busy = start
                | ((state_q == BUS_REQ)    && !flush   && !timeout)
                | ((state_q == BUS_ACCESS) && !bus_rdy && !timeout);

    assign bus_req     = bus_req_q;
    assign bus_as      = bus_as_q;
    assign bus_rw      = bus_rw_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign rd_data     = bus_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= BUS_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_as_q      <= 1'b0;
            bus_rw_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    cnt_q <= '0;
                    if (start) begin
                        state_q   <= BUS_REQ;
                        bus_req_q <= 1'b1;
                    end
                end
                BUS_REQ: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (flush || timeout) begin
                        state_q   <= BUS_IDLE;
                        cnt_q     <= '0;
                        bus_req_q <= 1'b0;
                    end else if (bus_grant) begin
                        state_q       <= BUS_ACCESS;
                        bus_as_q      <= 1'b1;
                        bus_rw_q      <= acc_rd;
                        bus_addr_q    <= acc_addr;
                        bus_wr_data_q <= acc_wr_data;
                    end
                end
                BUS_ACCESS: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (done || timeout) begin
                        state_q       <= BUS_IDLE;
                        cnt_q         <= '0;
                        bus_req_q     <= 1'b0;
                        bus_as_q      <= 1'b0;
                        bus_rw_q      <= 1'b0;
                        bus_addr_q    <= '0;
                        bus_wr_data_q <= '0;
                    end
                end
                default: begin
                    state_q <= BUS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: word loads/stores over the shared bus, misalignment and
// bus-timeout exceptions, forwarding result and the MEM/WB pipeline register.
import cpu_defs::*;

module stage_mem #(
    parameter int BUS_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] ex_pc,
    input  logic                   ex_en,
    input  logic                   ex_br_flag,
    input  logic [1:0]             ex_ctrl_op,
    input  logic [GPR_ADDR_W-1:0]  ex_dst_addr,
    input  logic                   ex_gpr_we_,
    input  logic [1:0]             ex_mem_op,
    input  logic [WORD-1:0]        ex_mem_wr_data,
    input  logic [EXP_W-1:0]       ex_exp_code,
    input  logic [WORD-1:0]        ex_out,
    output logic [WORD_ADDR_W-1:0] mem_pc,
    output logic                   mem_en,
    output logic                   mem_br_flag,
    output logic [1:0]             mem_ctrl_op,
    output logic [GPR_ADDR_W-1:0]  mem_dst_addr,
    output logic                   mem_gpr_we_,
    output logic [EXP_W-1:0]       mem_exp_code,
    output logic [WORD-1:0]        mem_out,
    output logic [WORD-1:0]        fwd_data,
    output logic                   busy,
    output logic                   bus_req,
    input  logic                   bus_grant,
    output logic                   bus_as,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [WORD-1:0]        bus_wr_data,
    input  logic [WORD-1:0]        bus_rd_data,
    input  logic                   bus_rdy
);

    memwb_t          memwb_q;
    memwb_t          memwb_d;
    logic            flush_pend_q;
    logic            flush_pend_d;

    logic            mem_req;
    logic            acc;
    logic            mis;
    logic            is_load;
    logic            done;
    logic            timeout;
    logic [WORD-1:0] rd_data;

    assign is_load = (ex_mem_op == MEM_OP_LOAD);
    assign mem_req = ex_en && is_mem_op(ex_mem_op) && (ex_exp_code == EXP_NONE);
    assign acc     = mem_req && (ex_out[1:0] == 2'b00);
    assign mis     = mem_req && (ex_out[1:0] != 2'b00);

    mem_bus_if #(
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .TO_W        (TO_W)
    ) u_bus (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .acc         (acc),
        .acc_rd      (is_load),
        .acc_addr    (ex_out[WORD-1:2]),
        .acc_wr_data (ex_mem_wr_data),
        .bus_grant   (bus_grant),
        .bus_rdy     (bus_rdy),
        .bus_rd_data (bus_rd_data),
        .bus_req     (bus_req),
        .bus_as      (bus_as),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .rd_data     (rd_data)
    );

    always_comb begin
        fwd_data = ex_out;
        if (mis || timeout) begin
            fwd_data = '0;
        end else if (done && is_load) begin
            fwd_data = rd_data;
        end
    end

    // A flush seen mid-transfer is remembered so the finished access is discarded.
    always_comb begin
        flush_pend_d = 1'b0;
        if (stall || busy) begin
            flush_pend_d = flush_pend_q || (flush && busy);
        end
    end

    always_comb begin
        memwb_d = memwb_q;
        if (!(stall || busy)) begin
            if (flush || flush_pend_q) begin
                memwb_d = MEMWB_BUBBLE;
            end else begin
                memwb_d.pc       = ex_pc;
                memwb_d.en       = ex_en;
                memwb_d.br_flag  = ex_br_flag;
                memwb_d.ctrl_op  = ex_ctrl_op;
                memwb_d.dst_addr = ex_dst_addr;
                memwb_d.out      = fwd_data;
                if (timeout) begin
                    memwb_d.exp_code = EXP_BUSERR;
                    memwb_d.gpr_we_  = 1'b1;
                end else if (mis) begin
                    memwb_d.exp_code = EXP_MISALIGN;
                    memwb_d.gpr_we_  = 1'b1;
                end else begin
                    memwb_d.exp_code = ex_exp_code;
                    memwb_d.gpr_we_  = (ex_exp_code != EXP_NONE) ? 1'b1 : ex_gpr_we_;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            memwb_q      <= MEMWB_BUBBLE;
            flush_pend_q <= 1'b0;
        end else begin
            memwb_q      <= memwb_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign mem_pc       = memwb_q.pc;
    assign mem_en       = memwb_q.en;
    assign mem_br_flag  = memwb_q.br_flag;
    assign mem_ctrl_op  = memwb_q.ctrl_op;
    assign mem_dst_addr = memwb_q.dst_addr;
    assign mem_gpr_we_  = memwb_q.gpr_we_;
    assign mem_exp_code = memwb_q.exp_code;
    assign mem_out      = memwb_q.out;

endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: a simple bus slave with programmable grant/ready delays
// and a transaction-level model of the expected stage result and timing.
module tb_stage_mem;

    localparam int BUS_TIMEOUT = 16;
    localparam int TO_W        = 5;
    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_LD  = 2'd1;
    localparam logic [1:0] OP_ST  = 2'd2;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic [29:0] ex_pc;
    logic        ex_en, ex_br_flag, ex_gpr_we_;
    logic [1:0]  ex_ctrl_op, ex_mem_op;
    logic [4:0]  ex_dst_addr;
    logic [31:0] ex_mem_wr_data, ex_out;
    logic [2:0]  ex_exp_code;
    logic [29:0] mem_pc;
    logic        mem_en, mem_br_flag, mem_gpr_we_;
    logic [1:0]  mem_ctrl_op;
    logic [4:0]  mem_dst_addr;
    logic [2:0]  mem_exp_code;
    logic [31:0] mem_out, fwd_data;
    logic        busy, bus_req, bus_grant, bus_as, bus_rw, bus_rdy;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data, bus_rd_data;

    int n_total = 0;
    int n_pass  = 0;
    int req_seen, as_seen;

    stage_mem #(.BUS_TIMEOUT(BUS_TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_ctrl_op(ex_ctrl_op),
        .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_mem_op(ex_mem_op),
        .ex_mem_wr_data(ex_mem_wr_data), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
        .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
        .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
        .mem_out(mem_out), .fwd_data(fwd_data), .busy(busy),
        .bus_req(bus_req), .bus_grant(bus_grant), .bus_as(bus_as), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    // Bus slave: grant after g request cycles, ready after r strobe cycles.
    // Called 1 time unit after a rising edge; returns at the falling edge.
    task automatic step_bus(input int g, input int r, input logic [31:0] rdata);
        bus_grant   = bus_req && !bus_as && (req_seen >= g);
        bus_rdy     = bus_as && (as_seen >= r);
        bus_rd_data = bus_rdy ? rdata : $urandom();
        #4;
        if (bus_req && !bus_as) req_seen++;
        if (bus_as) as_seen++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input string name, input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [2:0] ein, input logic en,
                           input logic gwe, input int g, input int r, input logic [31:0] rdata);
        logic [29:0] pc;
        logic        br;
        logic [1:0]  ctrl;
        logic [4:0]  dst;
        logic        has_mem, misal, access, tmo, fin;
        logic [31:0] e_out;
        logic [2:0]  e_exp;
        logic        e_we;
        int          e_cycles, busy_cnt, req_cnt, cyc;
        pc   = 30'($urandom());
        br   = 1'($urandom());
        ctrl = 2'($urandom());
        dst  = 5'($urandom());

        has_mem  = en && (op == OP_LD || op == OP_ST) && (ein == 3'd0);
        misal    = has_mem && (addr[1:0] != 2'b00);
        access   = has_mem && !misal;
        tmo      = access && (g + r >= BUS_TIMEOUT - 1);
        e_cycles = !access ? 0 : (tmo ? BUS_TIMEOUT : g + r + 2);
        if (tmo || misal)              e_out = 32'd0;
        else if (access && op == OP_LD) e_out = rdata;
        else                           e_out = addr;
        e_exp = tmo ? 3'd5 : (misal ? 3'd4 : ein);
        e_we  = (tmo || misal || ein != 3'd0) ? 1'b1 : gwe;

        ex_pc = pc; ex_en = en; ex_br_flag = br; ex_ctrl_op = ctrl; ex_dst_addr = dst;
        ex_gpr_we_ = gwe; ex_mem_op = op; ex_mem_wr_data = wdata; ex_exp_code = ein; ex_out = addr;
        req_seen = 0; as_seen = 0;
        busy_cnt = 0; req_cnt = 0; cyc = 0; fin = 1'b0;

        while (!fin && cyc < 64) begin
            step_bus(g, r, rdata);
            if (bus_req) req_cnt++;
            if (bus_as) begin
                n_total++;
                if ({bus_rw, bus_addr} !== {op == OP_LD, addr[31:2]})
                    $display("FAIL %s bus rw/addr: got %b/%h want %b/%h", name, bus_rw, bus_addr, op == OP_LD, addr[31:2]);
                else n_pass++;
                if (op == OP_ST) begin
                    n_total++;
                    if (bus_wr_data !== wdata)
                        $display("FAIL %s bus_wr_data: got %h want %h", name, bus_wr_data, wdata);
                    else n_pass++;
                end
            end
            if (!busy) begin
                fin = 1'b1;
                n_total++;
                if (fwd_data !== e_out)
                    $display("FAIL %s fwd_data: got %h want %h", name, fwd_data, e_out);
                else n_pass++;
            end else begin
                busy_cnt++;
            end
            next_cycle();
            cyc++;
        end
        bus_grant = 1'b0; bus_rdy = 1'b0; ex_en = 1'b0; ex_mem_op = OP_NOP;

        n_total++;
        if (!fin) begin
            $display("FAIL %s completion: busy still 1 after %0d cycles, want completion", name, cyc);
        end else begin
            n_pass++;
            n_total++;
            if ({mem_out, mem_exp_code, mem_gpr_we_} !== {e_out, e_exp, e_we})
                $display("FAIL %s result out/exp/we_: got %h/%0d/%b want %h/%0d/%b",
                         name, mem_out, mem_exp_code, mem_gpr_we_, e_out, e_exp, e_we);
            else n_pass++;
            n_total++;
            if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr} !== {pc, en, br, ctrl, dst})
                $display("FAIL %s passthrough: got %h want %h", name,
                         {mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr}, {pc, en, br, ctrl, dst});
            else n_pass++;
            n_total++;
            if (busy_cnt !== e_cycles)
                $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, e_cycles);
            else n_pass++;
            n_total++;
            if (req_cnt !== e_cycles)
                $display("FAIL %s bus_req cycles: got %0d want %0d", name, req_cnt, e_cycles);
            else n_pass++;
            n_total++;
            if ({bus_req, bus_as} !== 2'b00)
                $display("FAIL %s bus idle after completion: got req/as %b want 00", name, {bus_req, bus_as});
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = '0;
        ex_gpr_we_ = 1'b1; ex_mem_op = OP_NOP; ex_mem_wr_data = '0; ex_exp_code = '0; ex_out = '0;
        bus_grant = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
        repeat (3) next_cycle();
        reset = 1'b0;
        n_total++;
        if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out}
            !== {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0})
            $display("FAIL reset mem regs: got pc=%h en=%b we_=%b exp=%0d out=%h want zeros with we_=1",
                     mem_pc, mem_en, mem_gpr_we_, mem_exp_code, mem_out);
        else n_pass++;
        n_total++;
        if ({bus_req, bus_as, bus_rw, bus_addr, bus_wr_data} !== 64'd0)
            $display("FAIL reset bus: got req=%b as=%b rw=%b addr=%h wd=%h want all 0",
                     bus_req, bus_as, bus_rw, bus_addr, bus_wr_data);
        else n_pass++;
        #4;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_flush_req();
        ex_pc = 30'h123; ex_en = 1'b1; ex_br_flag = 1'b0; ex_ctrl_op = 2'd0; ex_dst_addr = 5'd7;
        ex_gpr_we_ = 1'b0; ex_mem_op = OP_LD; ex_mem_wr_data = '0; ex_exp_code = 3'd0; ex_out = 32'h300;
        req_seen = 0; as_seen = 0;
        step_bus(1000, 0, 32'h0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL flush_req idle busy: got %b want 1", busy);
        else n_pass++;
        next_cycle();
        n_total++;
        if (bus_req !== 1'b1) $display("FAIL flush_req bus_req in REQ: got %b want 1", bus_req);
        else n_pass++;
        flush = 1'b1;
        step_bus(1000, 0, 32'h0);
        n_total++;
        if (busy !== 1'b0) $display("FAIL flush_req busy under flush: got %b want 0", busy);
        else n_pass++;
        next_cycle();
        flush = 1'b0; ex_en = 1'b0; ex_mem_op = OP_NOP;
        n_total++;
        if ({bus_req, mem_en, mem_gpr_we_, mem_exp_code, mem_out} !== {1'b0, 1'b0, 1'b1, 3'd0, 32'd0})
            $display("FAIL flush_req bubble: got req=%b en=%b we_=%b exp=%0d out=%h want 0 0 1 0 0",
                     bus_req, mem_en, mem_gpr_we_, mem_exp_code, mem_out);
        else n_pass++;
        step_bus(0, 0, 32'h0);
        next_cycle();
        n_total++;
        if (bus_req !== 1'b0) $display("FAIL flush_req no restart: got bus_req %b want 0", bus_req);
        else n_pass++;
    endtask

    task automatic test_flush_access();
        int busy_cnt;
        int cyc;
        logic fin;
        ex_pc = 30'h55; ex_en = 1'b1; ex_br_flag = 1'b1; ex_ctrl_op = 2'd1; ex_dst_addr = 5'd3;
        ex_gpr_we_ = 1'b0; ex_mem_op = OP_ST; ex_mem_wr_data = 32'hCAFE0001; ex_exp_code = 3'd0;
        ex_out = 32'h400;
        req_seen = 0; as_seen = 0; busy_cnt = 0; cyc = 0; fin = 1'b0;
        while (!fin && cyc < 32) begin
            flush = bus_as && (as_seen == 0);
            step_bus(0, 3, 32'h0);
            if (!busy) fin = 1'b1;
            else busy_cnt++;
            next_cycle();
            cyc++;
        end
        flush = 1'b0; bus_grant = 1'b0; bus_rdy = 1'b0; ex_en = 1'b0; ex_mem_op = OP_NOP;
        n_total++;
        if (busy_cnt !== 5) $display("FAIL flush_access busy cycles: got %0d want 5", busy_cnt);
        else n_pass++;
        n_total++;
        if ({bus_req, bus_as, mem_en, mem_gpr_we_, mem_exp_code, mem_out} !== {2'b00, 1'b0, 1'b1, 3'd0, 32'd0})
            $display("FAIL flush_access bubble: got req=%b as=%b en=%b we_=%b exp=%0d out=%h want 0 0 0 1 0 0",
                     bus_req, bus_as, mem_en, mem_gpr_we_, mem_exp_code, mem_out);
        else n_pass++;
    endtask

    task automatic test_stall();
        run_txn("stall_pre", OP_NOP, 32'hA5A50001, 32'h0, 3'd0, 1'b1, 1'b0, 0, 0, 32'h0);
        stall = 1'b1;
        ex_en = 1'b1; ex_mem_op = OP_NOP; ex_exp_code = 3'd0; ex_out = 32'h5A5A0002;
        step_bus(0, 0, 32'h0);
        next_cycle();
        n_total++;
        if (mem_out !== 32'hA5A50001) $display("FAIL stall hold: got %h want a5a50001", mem_out);
        else n_pass++;
        stall = 1'b0;
        step_bus(0, 0, 32'h0);
        next_cycle();
        ex_en = 1'b0;
        n_total++;
        if (mem_out !== 32'h5A5A0002) $display("FAIL stall release: got %h want 5a5a0002", mem_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        ex_pc = 30'h77; ex_en = 1'b1; ex_br_flag = 1'b1; ex_ctrl_op = 2'd2; ex_dst_addr = 5'd9;
        ex_gpr_we_ = 1'b0; ex_mem_op = OP_LD; ex_mem_wr_data = '0; ex_exp_code = 3'd0; ex_out = 32'h800;
        req_seen = 0; as_seen = 0; k = 0;
        while (!bus_as && k < 8) begin
            step_bus(0, 1000, 32'h0);
            next_cycle();
            k++;
        end
        n_total++;
        if (bus_as !== 1'b1) $display("FAIL reset_mid reach ACCESS: got bus_as %b want 1", bus_as);
        else n_pass++;
        reset = 1'b1; ex_en = 1'b0; ex_mem_op = OP_NOP; bus_grant = 1'b0; bus_rdy = 1'b0;
        next_cycle();
        reset = 1'b0;
        n_total++;
        if ({bus_req, bus_as, bus_rw, bus_addr, bus_wr_data} !== 64'd0)
            $display("FAIL reset_mid bus: got req=%b as=%b rw=%b addr=%h want all 0", bus_req, bus_as, bus_rw, bus_addr);
        else n_pass++;
        n_total++;
        if ({mem_pc, mem_en, mem_br_flag, mem_ctrl_op, mem_dst_addr, mem_gpr_we_, mem_exp_code, mem_out}
            !== {30'd0, 1'b0, 1'b0, 2'd0, 5'd0, 1'b1, 3'd0, 32'd0})
            $display("FAIL reset_mid mem regs: got en=%b we_=%b exp=%0d out=%h want 0 1 0 0",
                     mem_en, mem_gpr_we_, mem_exp_code, mem_out);
        else n_pass++;
        #4;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_mid busy: got %b want 0", busy);
        else n_pass++;
        next_cycle();
        run_txn("reset_mid_new_load", OP_LD, 32'h0000_0900, 32'h0, 3'd0, 1'b1, 1'b0, 0, 0, 32'h0BADF00D);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] addr;
            logic [2:0]  ein;
            int          g, r;
            op   = 2'($urandom_range(0, 3));
            addr = $urandom();
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            case ($urandom_range(0, 7))
                6:       ein = 3'd1;
                7:       ein = 3'd3;
                default: ein = 3'd0;
            endcase
            g = $urandom_range(0, 4);
            r = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 4);
            run_txn($sformatf("rand%0d", i), op, addr, $urandom(), ein, ($urandom_range(0, 7) != 0),
                    1'($urandom()), g, r, $urandom());
        end
    endtask

    initial begin
        test_reset();
        run_txn("load_basic", OP_LD, 32'h0000_0100, 32'h0, 3'd0, 1'b1, 1'b0, 0, 0, 32'hDEADBEEF);
        run_txn("store_delayed", OP_ST, 32'h0000_0204, 32'h12345678, 3'd0, 1'b1, 1'b1, 3, 2, 32'h0);
        run_txn("misalign", OP_LD, 32'h0000_0102, 32'h0, 3'd0, 1'b1, 1'b0, 0, 0, 32'h0);
        run_txn("timeout", OP_LD, 32'h0000_0100, 32'h0, 3'd0, 1'b1, 1'b0, 0, 1000, 32'h0);
        run_txn("rdy_at_expiry", OP_LD, 32'h0000_0180, 32'h0, 3'd0, 1'b1, 1'b0, 0, 14, 32'h13572468);
        run_txn("timeout_late_grant", OP_ST, 32'h0000_0184, 32'h1, 3'd0, 1'b1, 1'b0, 14, 1, 32'h0);
        run_txn("timeout_in_req", OP_LD, 32'h0000_0188, 32'h0, 3'd0, 1'b1, 1'b0, 1000, 0, 32'h0);
        run_txn("exc_passthru", OP_ST, 32'h0000_0204, 32'h1, 3'd3, 1'b1, 1'b0, 0, 0, 32'h0);
        test_flush_req();
        run_txn("after_flush", OP_ST, 32'h0000_0208, 32'h87654321, 3'd0, 1'b1, 1'b0, 1, 1, 32'h0);
        test_flush_access();
        test_stall();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
